// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - shared constants for the MMIO UART transmitter
package uart_tx_mmio_pkg;

    // FSM state encodings (2-bit)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // 8N1 frame: start + 8 data + stop
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    // Clocks per line bit; integer division truncates
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// rtl/uart_tx_mmio_sync_fifo.sv - circular byte FIFO with pointers plus count
module uart_tx_mmio_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage array; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at AW bits; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - MMIO-fed 8N1 UART transmitter with byte FIFO
module uart_tx_mmio #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        busy,
    output logic        overflow,
    output logic        tx
);

    import uart_tx_mmio_pkg::*;

    localparam int               DIV      = calc_div(CLK_FREQ, BAUD);
    localparam int               CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tx_q;
    logic             overflow_q;
    logic             pop;
    logic             push;
    logic             bit_end;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             unused_wr_hi;

    // Only the low byte of the bus carries data
    assign unused_wr_hi = ^wr_data[15:8];

    // A write while full is dropped even if the FSM pops that cycle
    assign push    = wr_en & ~fifo_full;
    assign bit_end = (cnt == CNT_LAST);

    uart_tx_mmio_sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (wr_data[7:0]),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Pop when idle with data waiting, or at the end of a stop bit for back-to-back frames
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE) begin
                pop = 1'b1;
            end else if (state == ST_STOP && bit_end) begin
                pop = 1'b1;
            end
        end
    end

    // Frame sequencer: baud counter, shift register and registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift <= fifo_head;
                        tx_q  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_START;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        tx_q    <= shift[0];
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == BIT_LAST) begin
                            tx_q  <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            tx_q    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (!fifo_empty) begin
                            shift <= fifo_head;
                            tx_q  <= 1'b0;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Sticky record of any write lost to a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign tx       = tx_q;
    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign busy     = (state != ST_IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        busy;
    logic        overflow;
    logic        tx;

    int total = 0;
    int fails = 0;

    uart_tx_mmio #(
        .CLK_FREQ (8),
        .BAUD     (1),
        .FIFO_AW  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_fall(output int waited);
        waited = 0;
        while (tx !== 1'b0 && waited < 300) begin
            step();
            waited++;
        end
    endtask

    // Samples every cycle of one frame; skip = cycles of the start bit already elapsed
    task automatic frame_check(input string tag, input int skip, input logic [7:0] b);
        logic [9:0] bits;
        logic       stable;
        bits   = '1;
        stable = 1'b1;
        for (int k = skip; k < 80; k++) begin
            if (k == skip || (k % 8) == 0) begin
                bits[k/8] = tx;
            end else if (tx !== bits[k/8]) begin
                stable = 1'b0;
            end
            step();
        end
        check({tag, "_frame"}, {22'd0, bits}, {22'd0, 1'b1, b, 1'b0});
        check({tag, "_stable"}, {31'd0, stable}, 32'd1);
    endtask

    initial begin
        int   waited;
        logic quiet;
        logic full_seen;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 16'h0000;

        // 1. reset state and idle line
        repeat (5) step();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (100) begin
            step();
            if (tx !== 1'b1) quiet = 1'b0;
        end
        check("idle_quiet", {31'd0, quiet}, 32'd1);

        // 2. single byte, upper bus byte ignored
        write_byte(16'hAB55);
        check("t2_lat_n", {31'd0, tx}, 32'd1);
        step();
        check("t2_lat_n1", {31'd0, tx}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd1);
        frame_check("t2", 0, 8'h55);
        check("t2_busy_fall", {31'd0, busy}, 32'd0);
        check("t2_tx_idle", {31'd0, tx}, 32'd1);

        // 3. burst of four, never full, contiguous frames
        repeat (3) step();
        full_seen = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            write_byte(16'(i));
            if (full !== 1'b0) full_seen = 1'b1;
        end
        check("t3_never_full", {31'd0, full_seen}, 32'd0);
        frame_check("t3_f1", 2, 8'h01);
        for (int i = 2; i <= 4; i++) begin
            wait_fall(waited);
            check("t3_gap", waited, 0);
            frame_check("t3_fn", 0, 8'(i));
        end
        check("t3_busy_fall", {31'd0, busy}, 32'd0);

        // 4. overflow: six writes, sixth dropped
        repeat (3) step();
        for (int i = 0; i < 6; i++) begin
            write_byte(16'h0010 + 16'(i));
            if (i == 4) check("t4_full", {31'd0, full}, 32'd1);
        end
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        frame_check("t4_f1", 4, 8'h10);
        for (int i = 1; i < 5; i++) begin
            wait_fall(waited);
            check("t4_gap", waited, 0);
            frame_check("t4_fn", 0, 8'h10 + 8'(i));
        end
        check("t4_busy_fall", {31'd0, busy}, 32'd0);
        quiet = 1'b1;
        repeat (30) begin
            step();
            if (tx !== 1'b1) quiet = 1'b0;
        end
        check("t4_no_sixth", {31'd0, quiet}, 32'd1);
        check("t4_sticky", {31'd0, overflow}, 32'd1);
        check("t4_full_clr", {31'd0, full}, 32'd0);

        // 5. push and pop in the same cycle at the end of a stop bit
        write_byte(16'h0021);
        repeat (19) step();
        write_byte(16'h0022);
        repeat (60) step();
        check("t5_in_stop", {31'd0, tx}, 32'd1);
        write_byte(16'h007E);
        check("t5_restart", {31'd0, tx}, 32'd0);
        check("t5_not_full", {31'd0, full}, 32'd0);
        frame_check("t5_b", 0, 8'h22);
        wait_fall(waited);
        check("t5_gap", waited, 0);
        frame_check("t5_c", 0, 8'h7E);
        check("t5_busy_fall", {31'd0, busy}, 32'd0);
        check("t5_sticky", {31'd0, overflow}, 32'd1);

        // 6. reset during data bit 3 (a zero bit of 0xA5), with a byte still queued
        write_byte(16'h00A5);
        write_byte(16'h0066);
        repeat (35) step();
        check("t6_pre", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_tx_async", {31'd0, tx}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_full", {31'd0, full}, 32'd0);
        check("t6_overflow", {31'd0, overflow}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (30) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("t6_fifo_flushed", {31'd0, quiet}, 32'd1);
        write_byte(16'h00C3);
        step();
        check("t6_start", {31'd0, tx}, 32'd0);
        frame_check("t6", 0, 8'hC3);
        check("t6_busy_fall", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
